// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared vertex, triangle and scheduler-state types.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  // Vertex packed as {z, y, x}, each an IEEE-754 single, x in the low word.
  typedef logic [2:0][31:0] vertex_t;

  typedef struct packed {
    vertex_t p1;
    vertex_t p2;
    vertex_t p3;
  } triangle_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    START      = 3'd2,
    RUN        = 3'd3,
    FRAME_DONE = 3'd4,
    RECOVER    = 3'd5
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/tri_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tri_fifo
// Description : Synchronous FIFO of triangles with show-ahead head output.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  triangle_t              din,
  output triangle_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_AW = $clog2(DEPTH);

  triangle_t           r_mem [DEPTH];
  logic [c_AW-1:0]     r_wr;
  logic [c_AW-1:0]     r_rd;
  logic [c_AW:0]       r_count;
  logic                w_push;
  logic                w_pop;

  // A push is refused while full even if a pop frees a slot in the same cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full  = (r_count == (c_AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/raster_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : raster_scheduler
// Description : Queues triangles and sequences rasterizer_unit one at a time,
//               with frame completion tracking and a hang watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_scheduler
  import gpu_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tri_valid,
  output logic             tri_ready,
  input  logic [95:0]      tri_p1,
  input  logic [95:0]      tri_p2,
  input  logic [95:0]      tri_p3,
  input  logic             frame_end,
  output logic [95:0]      ru_p1,
  output logic [95:0]      ru_p2,
  output logic [95:0]      ru_p3,
  output logic             ru_start,
  input  logic             ru_done,
  output logic             ru_reset,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_tris,
  output logic             timeout_err
);

  localparam int              c_CW       = $clog2(DEPTH) + 1;
  localparam int              c_LW       = c_CW + 1;
  localparam int              c_WW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WW-1:0] c_WD_LAST  = c_WW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  sched_state_t     r_state;
  logic [c_WW-1:0]  r_wd;
  logic [CNT_W-1:0] r_tri_cnt;
  logic             r_pending;
  logic [c_LW-1:0]  r_left;

  triangle_t        w_din;
  triangle_t        w_head;
  logic             w_full;
  logic             w_empty;
  logic [c_CW-1:0]  w_count;
  logic             w_push;
  logic             w_pop;
  logic             w_inflight;
  logic             w_timeout;
  logic             w_complete;
  logic             w_retire;

  assign tri_ready  = reset_n && !w_full;
  assign w_push     = tri_valid && tri_ready;
  assign w_pop      = (r_state == LOAD);
  assign w_din      = {tri_p1, tri_p2, tri_p3};
  assign busy       = !w_empty || (r_state != IDLE);

  assign w_inflight = (r_state == START) || (r_state == RUN);
  assign w_timeout  = w_inflight && (r_wd == c_WD_LAST);
  assign w_complete = (r_state == RUN) && ru_done && !w_timeout;
  assign w_retire   = w_timeout || w_complete;

  tri_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (w_din),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_wd        <= '0;
      r_tri_cnt   <= '0;
      r_pending   <= 1'b0;
      r_left      <= '0;
      ru_p1       <= '0;
      ru_p2       <= '0;
      ru_p3       <= '0;
      ru_start    <= 1'b0;
      ru_reset    <= 1'b1;
      frame_done  <= 1'b0;
      frame_tris  <= '0;
      timeout_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      ru_reset   <= 1'b0;

      // r_left counts the not-yet-retired triangles that belong to the ending
      // frame; FIFO order guarantees they are always the oldest ones.
      if (frame_end && !r_pending) begin
        r_pending <= 1'b1;
        r_left    <= c_LW'(w_count) + c_LW'(w_inflight) + c_LW'(w_push)
                     - c_LW'(w_retire);
      end else if (r_pending && w_retire) begin
        r_left <= r_left - 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (r_pending && (r_left == '0)) begin
            frame_done <= 1'b1;
            frame_tris <= r_tri_cnt;
            r_tri_cnt  <= '0;
            r_pending  <= 1'b0;
            r_state    <= FRAME_DONE;
          end else if (!w_empty) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          ru_p1    <= w_head.p1;
          ru_p2    <= w_head.p2;
          ru_p3    <= w_head.p3;
          ru_start <= 1'b1;
          r_wd     <= '0;
          r_state  <= START;
        end
        START, RUN: begin
          if (w_timeout) begin
            ru_start    <= 1'b0;
            ru_reset    <= 1'b1;
            timeout_err <= 1'b1;
            r_state     <= RECOVER;
          end else begin
            r_wd <= r_wd + 1'b1;
            if ((r_state == START) && !ru_done) begin
              ru_start <= 1'b0;
              r_state  <= RUN;
            end else if (w_complete) begin
              if (r_tri_cnt != c_CNT_MAX) begin
                r_tri_cnt <= r_tri_cnt + 1'b1;
              end
              r_state <= IDLE;
            end
          end
        end
        FRAME_DONE: r_state <= IDLE;
        RECOVER:    r_state <= IDLE;
        default:    r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_raster_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_raster_scheduler
// Description : Scoreboard bench for raster_scheduler with a behavioural
//               rasterizer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raster_scheduler;

  localparam int c_DEPTH   = 4;
  localparam int c_TIMEOUT = 150;
  localparam int c_CNT_W   = 16;
  localparam int c_RUN_LEN = 100;

  localparam logic [95:0] c_V1_P1 = {32'h3f800000, 32'h428a0000, 32'h428a0000};
  localparam logic [95:0] c_V1_P2 = {32'h3f800000, 32'h43290000, 32'h428a0000};
  localparam logic [95:0] c_V1_P3 = {32'h3f800000, 32'h428a0000, 32'h43290000};

  logic               clk       = 1'b0;
  logic               reset_n   = 1'b0;
  logic               tri_valid = 1'b0;
  logic               frame_end = 1'b0;
  logic [95:0]        tri_p1    = '0;
  logic [95:0]        tri_p2    = '0;
  logic [95:0]        tri_p3    = '0;
  logic               ru_done   = 1'b1;
  logic               tri_ready;
  logic [95:0]        ru_p1, ru_p2, ru_p3;
  logic               ru_start, ru_reset, busy, frame_done, timeout_err;
  logic [c_CNT_W-1:0] frame_tris;

  logic               m_busy    = 1'b0;
  int                 m_run     = 0;
  logic               hang_mode = 1'b0;

  int                 n_vec     = 0;
  int                 n_err     = 0;
  int                 start_cnt = 0;
  logic [287:0]       exp_tri   [$];
  logic [c_CNT_W-1:0] exp_frame [$];

  always #5 clk = ~clk;

  raster_scheduler #(
    .DEPTH          (c_DEPTH),
    .TIMEOUT_CYCLES (c_TIMEOUT),
    .CNT_W          (c_CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tri_valid   (tri_valid),
    .tri_ready   (tri_ready),
    .tri_p1      (tri_p1),
    .tri_p2      (tri_p2),
    .tri_p3      (tri_p3),
    .frame_end   (frame_end),
    .ru_p1       (ru_p1),
    .ru_p2       (ru_p2),
    .ru_p3       (ru_p3),
    .ru_start    (ru_start),
    .ru_done     (ru_done),
    .ru_reset    (ru_reset),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_tris  (frame_tris),
    .timeout_err (timeout_err)
  );

  // Rasterizer: done drops 1 cycle after start, rises c_RUN_LEN cycles later.
  // In hang mode it ignores start until reset.
  always @(posedge clk) begin
    if (ru_reset) begin
      ru_done <= 1'b1;
      m_busy  <= 1'b0;
      m_run   <= 0;
    end else if (m_busy) begin
      if (m_run == c_RUN_LEN - 1) begin
        ru_done <= 1'b1;
        m_busy  <= 1'b0;
      end else begin
        m_run <= m_run + 1;
      end
    end else if (ru_start && ru_done && !hang_mode) begin
      ru_done <= 1'b0;
      m_busy  <= 1'b1;
      m_run   <= 0;
    end
  end

  function automatic void chk(input string nm, input logic [287:0] act,
                              input logic [287:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic monitor();
    logic         prev_start = 1'b0;
    logic [287:0] e;
    forever begin
      @(negedge clk);
      if (ru_start && !prev_start) begin
        start_cnt++;
        if (exp_tri.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          e = exp_tri.pop_front();
          chk("ru_vertices", {ru_p1, ru_p2, ru_p3}, e);
        end
      end
      prev_start = ru_start;
      if (frame_done) begin
        if (exp_frame.size() == 0) chk("unexpected_frame_done", 1, 0);
        else                       chk("frame_tris", frame_tris, exp_frame.pop_front());
      end
    end
  endtask

  task automatic push_tri(input logic [95:0] a, b, c, input logic fe);
    int n = 0;
    tri_valid = 1'b1;
    tri_p1 = a; tri_p2 = b; tri_p3 = c;
    while (!tri_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tri_ready) chk("push_ready_timeout", tri_ready, 1);
    frame_end = fe;
    @(posedge clk);
    exp_tri.push_back({a, b, c});
    @(negedge clk);
    tri_valid = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic pulse_frame(input logic [c_CNT_W-1:0] exp_n);
    frame_end = 1'b1;
    exp_frame.push_back(exp_n);
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tri_ready", tri_ready, 0);
    chk("rst_ru_start", ru_start, 0);
    chk("rst_ru_reset", ru_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_tris", frame_tris, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_ru_p1", ru_p1, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_ru_reset", ru_reset, 0);
    chk("rel_tri_ready", tri_ready, 1);

    // Empty frame: frame_done one cycle after the frame_end edge
    pulse_frame(0);
    chk("empty_frame_early", frame_done, 0);
    @(negedge clk);
    chk("empty_frame_done", frame_done, 1);
    wait_idle("idle_empty_frame");

    // Single triangle and start latency
    push_tri(c_V1_P1, c_V1_P2, c_V1_P3, 1'b0);
    chk("lat_e0", ru_start, 0);
    @(negedge clk);
    chk("lat_e1", ru_start, 0);
    @(negedge clk);
    chk("lat_e2", ru_start, 1);
    wait_idle("idle_single");
    chk("single_start_count", start_cnt, 1);

    // Six back-to-back with a slow rasterizer
    for (int i = 0; i < 6; i++) begin
      push_tri({32'h3f800000, 32'(i + 10), 32'(i + 100)},
               {32'h40000000, 32'(i + 20), 32'(i + 200)},
               {32'h40400000, 32'(i + 30), 32'(i + 300)}, 1'b0);
      if (i == 4) chk("full_after_5th", tri_ready, 0);
    end
    wait_idle("idle_six");
    chk("six_start_count", start_cnt, 7);
    pulse_frame(7);
    wait_idle("idle_frame7");

    // Frame boundary on the 3rd accept, two more belong to the next frame
    for (int i = 0; i < 5; i++) begin
      push_tri({32'(i), 32'h11, 32'h12}, {32'(i), 32'h21, 32'h22},
               {32'(i), 32'h31, 32'h32}, (i == 2));
      if (i == 2) exp_frame.push_back(3);
    end
    wait_idle("idle_frame3");
    pulse_frame(2);
    wait_idle("idle_frame2");

    // Watchdog: first triangle hangs, second completes
    hang_mode = 1'b1;
    push_tri({32'hdead, 32'h1, 32'h2}, {32'hdead, 32'h3, 32'h4},
             {32'hdead, 32'h5, 32'h6}, 1'b0);
    push_tri({32'hbeef, 32'h1, 32'h2}, {32'hbeef, 32'h3, 32'h4},
             {32'hbeef, 32'h5, 32'h6}, 1'b0);
    n = 0;
    while (!ru_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!ru_reset && n < 1000) begin
      @(negedge clk);
      n++;
    end
    hang_mode = 1'b0;
    chk("watchdog_cycles", n, c_TIMEOUT);
    chk("timeout_err_set", timeout_err, 1);
    @(negedge clk);
    chk("ru_reset_one_cycle", ru_reset, 0);
    wait_idle("idle_after_recover");
    chk("timeout_err_sticky", timeout_err, 1);
    pulse_frame(1);
    wait_idle("idle_frame1");

    // Reset mid-RUN with two triangles queued
    for (int i = 0; i < 3; i++) begin
      push_tri({32'(i), 32'h77, 32'h78}, {32'(i), 32'h79, 32'h7a},
               {32'(i), 32'h7b, 32'h7c}, 1'b0);
    end
    n = 0;
    while (!ru_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (ru_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ru_start", ru_start, 0);
    chk("mid_rst_ru_reset", ru_reset, 1);
    chk("mid_rst_tri_ready", tri_ready, 0);
    chk("mid_rst_frame_tris", frame_tris, 0);
    chk("mid_rst_timeout_err", timeout_err, 0);
    chk("mid_rst_ru_p1", ru_p1, 0);
    exp_tri.delete();
    reset_n = 1'b1;
    @(negedge clk);
    pulse_frame(0);
    wait_idle("idle_post_reset");

    repeat (5) @(negedge clk);
    chk("exp_tri_drained", exp_tri.size(), 0);
    chk("exp_frame_drained", exp_frame.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
